bpi_flash_access_arbiter: RTL and testbench
===========================================

// Module: bpi_flash_access_arbiter
// PURPOSE
//  Shares the single BPI flash PHY between the write FSM (word writes) and the read FSM (word reads).
//  Grants one requester at a time (2-way round robin) and issues a unified op stream to the PHY.
//  Holds the grant until the PHY signals completion, then routes read data back to the read FSM.
//  Exactly one op is outstanding at the PHY at any time.
// PARAMETERS
//  C_MEM_WIDTH       16         flash data bus width, bits
//  C_MEM_SIZE        134217728  flash size, bytes; C_ADDR_W = $clog2(8*C_MEM_SIZE/C_MEM_WIDTH)
//  C_TIMEOUT_CYCLES  65535      PHY completion watchdog limit (used only with BPI_FLASH_ARB_TIMEOUT_EN)
// PORTS
//  clk                clk  in   1            clock
//  rst_n              in   1                 synchronous, active-low reset
//  enable             in   1                 1: new grants allowed
//  busy               out  1                 1: op in progress (state != ST_IDLE)
//  s_axis_wr_tdata    in   C_MEM_WIDTH       write data
//  s_axis_wr_tdest    in   C_ADDR_W          write word address
//  s_axis_wr_tvalid   in   1 / s_axis_wr_tready out 1
//  s_axis_rd_tdata    in   C_ADDR_W          read word address
//  s_axis_rd_tvalid   in   1 / s_axis_rd_tready out 1
//  m_axis_rd_tdata    out  C_MEM_WIDTH       read data returned to read FSM
//  m_axis_rd_tuser    out  1                 1: read aborted by timeout
//  m_axis_rd_tvalid   out  1 / m_axis_rd_tready in 1
//  m_axis_op_tdata    out  C_MEM_WIDTH       write data (0 for reads)
//  m_axis_op_tdest    out  C_ADDR_W          word address
//  m_axis_op_tuser    out  1                 1: write, 0: read
//  m_axis_op_tvalid   out  1 / m_axis_op_tready in 1
//  s_phy_done_tdata   in   C_MEM_WIDTH       read data from PHY (don't care for writes)
//  s_phy_done_tvalid  in   1                 1-cycle completion pulse; no ready
//  wr_timeout         out  1                 1-cycle pulse: write aborted by timeout
// BEHAVIOUR
//  Reset: state ST_IDLE, last_grant=RD (first contested grant goes to WR); all outputs 0.
//  s_axis_*_tready combinational: (state==ST_IDLE) & enable & grant_*; at most one high per cycle.
//  Grant: only one valid -> that one; both valid -> the one != last_grant; last_grant updated on accept.
//  ST_IDLE: on accept latch addr/data/dir into m_axis_op_*, op_tvalid<=1, -> ST_ISSUE (op visible N+1).
//  ST_ISSUE: hold m_axis_op_* stable; on op handshake op_tvalid<=0, -> ST_WAIT.
//  ST_WAIT: s_phy_done_tvalid sampled only here (pulses in other states ignored).
//   done & write -> ST_IDLE. done & read -> latch tdata, rd_tuser<=0, rd_tvalid<=1, -> ST_RETURN.
//  ST_RETURN: hold m_axis_rd_*; on rd handshake rd_tvalid<=0 -> ST_IDLE.
//  Min turnaround: accept at N, next accept no earlier than cycle after return to ST_IDLE.
//  enable low mid-op: current op completes normally; no new grant until enable high.
//  Reset mid-op: abort at once, outputs to reset values; a late PHY done is ignored (arrives in ST_IDLE).
//  busy = (state != ST_IDLE), registered with state.
// CONFIGURATION
//  BPI_FLASH_ARB_TIMEOUT_EN defined: counter clears on ST_WAIT entry, increments each ST_WAIT cycle;
//   at C_TIMEOUT_CYCLES-1 without done: write -> wr_timeout pulse 1 cycle, -> ST_IDLE;
//   read -> rd_tdata=0, rd_tuser=1, -> ST_RETURN. done on the limit cycle wins (normal completion).
//  Undefined: ST_WAIT waits indefinitely; no counter; m_axis_rd_tuser and wr_timeout tied 0.
// STRUCTURE
//  bpi_flash_pkg: state enum {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RETURN}, requester enum {REQ_WR, REQ_RD}.
//  Sub-module bpi_flash_rr_arbiter: 2-way round-robin grant from valids + last_grant; purely comb.
//  Top: FSM, op/result registers, optional watchdog counter.
// TESTING
//  Single write addr 0x1234 data 0xBEEF, op_tready=1, done 3 cycles later -> op {0xBEEF,0x1234,tuser=1}, busy 0.
//  Single read addr 0x0010, PHY done tdata 0xA5A5 -> m_axis_rd_tdata 0xA5A5 tuser 0, op tuser 0 tdata 0.
//  WR and RD valid continuously, 4 ops -> grant order WR,RD,WR,RD; never two tready in same cycle.
//  op_tready low 5 cycles, rd_tready low 3 cycles -> op/rd outputs stable, no new accept meanwhile.
//  TIMEOUT_EN, C_TIMEOUT_CYCLES=16, no done on write -> wr_timeout 1 pulse; on read -> tdata 0, tuser 1.
//  rst_n low in ST_WAIT, done pulses after release -> ignored, state ST_IDLE, all outputs 0.

Source files
------------

// File: rtl/bpi_flash_pkg.sv
// Shared types for the BPI flash access arbiter: FSM states and requester identities.
package bpi_flash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETURN
  } state_e;

  typedef enum logic {
    REQ_WR,
    REQ_RD
  } req_e;

endpackage

// File: rtl/bpi_flash_rr_arbiter.sv
// Two-way round-robin grant between the write and read requesters (purely combinational).
module bpi_flash_rr_arbiter
  import bpi_flash_pkg::*;
(
  input  logic wr_valid,
  input  logic rd_valid,
  input  req_e last_grant,
  output logic grant_wr,
  output logic grant_rd
);

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant_wr = wr_valid & (~rd_valid | (last_grant == REQ_RD));
    grant_rd = rd_valid & ~grant_wr;
  end

endmodule

// File: rtl/bpi_flash_access_arbiter.sv
// Shares one BPI flash PHY between write and read FSMs; one op outstanding at a time.
// Optional PHY completion watchdog is enabled by defining BPI_FLASH_ARB_TIMEOUT_EN.
module bpi_flash_access_arbiter
  import bpi_flash_pkg::*;
#(
  parameter int C_MEM_WIDTH      = 16,
  parameter int C_MEM_SIZE       = 134217728,
  parameter int C_TIMEOUT_CYCLES = 65535,
  localparam int C_ADDR_W        = $clog2(8 * C_MEM_SIZE / C_MEM_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic                   busy,
  input  logic [C_MEM_WIDTH-1:0] s_axis_wr_tdata,
  input  logic [C_ADDR_W-1:0]    s_axis_wr_tdest,
  input  logic                   s_axis_wr_tvalid,
  output logic                   s_axis_wr_tready,
  input  logic [C_ADDR_W-1:0]    s_axis_rd_tdata,
  input  logic                   s_axis_rd_tvalid,
  output logic                   s_axis_rd_tready,
  output logic [C_MEM_WIDTH-1:0] m_axis_rd_tdata,
  output logic                   m_axis_rd_tuser,
  output logic                   m_axis_rd_tvalid,
  input  logic                   m_axis_rd_tready,
  output logic [C_MEM_WIDTH-1:0] m_axis_op_tdata,
  output logic [C_ADDR_W-1:0]    m_axis_op_tdest,
  output logic                   m_axis_op_tuser,
  output logic                   m_axis_op_tvalid,
  input  logic                   m_axis_op_tready,
  input  logic [C_MEM_WIDTH-1:0] s_phy_done_tdata,
  input  logic                   s_phy_done_tvalid,
  output logic                   wr_timeout
);

  state_e state;
  req_e   last_grant;
  logic   grant_wr;
  logic   grant_rd;
  logic   wr_accept;
  logic   rd_accept;

  bpi_flash_rr_arbiter u_rr_arbiter (
    .wr_valid   (s_axis_wr_tvalid),
    .rd_valid   (s_axis_rd_tvalid),
    .last_grant (last_grant),
    .grant_wr   (grant_wr),
    .grant_rd   (grant_rd)
  );

  assign s_axis_wr_tready = (state == ST_IDLE) & enable & grant_wr;
  assign s_axis_rd_tready = (state == ST_IDLE) & enable & grant_rd;
  assign wr_accept        = s_axis_wr_tready & s_axis_wr_tvalid;
  assign rd_accept        = s_axis_rd_tready & s_axis_rd_tvalid;

`ifdef BPI_FLASH_ARB_TIMEOUT_EN
  localparam int C_CNT_W = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  logic [C_CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (C_TIMEOUT_CYCLES != 0);
  assign m_axis_rd_tuser    = 1'b0;
  assign wr_timeout         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      last_grant       <= REQ_RD;
      busy             <= 1'b0;
      m_axis_op_tdata  <= '0;
      m_axis_op_tdest  <= '0;
      m_axis_op_tuser  <= 1'b0;
      m_axis_op_tvalid <= 1'b0;
      m_axis_rd_tdata  <= '0;
      m_axis_rd_tvalid <= 1'b0;
`ifdef BPI_FLASH_ARB_TIMEOUT_EN
      m_axis_rd_tuser  <= 1'b0;
      wr_timeout       <= 1'b0;
      wait_cnt         <= '0;
`endif
    end else begin
`ifdef BPI_FLASH_ARB_TIMEOUT_EN
      wr_timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (wr_accept) begin
            m_axis_op_tdata  <= s_axis_wr_tdata;
            m_axis_op_tdest  <= s_axis_wr_tdest;
            m_axis_op_tuser  <= 1'b1;
            m_axis_op_tvalid <= 1'b1;
            last_grant       <= REQ_WR;
            busy             <= 1'b1;
            state            <= ST_ISSUE;
          end else if (rd_accept) begin
            m_axis_op_tdata  <= '0;
            m_axis_op_tdest  <= s_axis_rd_tdata;
            m_axis_op_tuser  <= 1'b0;
            m_axis_op_tvalid <= 1'b1;
            last_grant       <= REQ_RD;
            busy             <= 1'b1;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_axis_op_tready) begin
            m_axis_op_tvalid <= 1'b0;
            state            <= ST_WAIT;
`ifdef BPI_FLASH_ARB_TIMEOUT_EN
            wait_cnt         <= '0;
`endif
          end
        end
        ST_WAIT: begin
          // A done pulse on the limit cycle still counts as normal completion.
          if (s_phy_done_tvalid) begin
            if (m_axis_op_tuser) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              m_axis_rd_tdata  <= s_phy_done_tdata;
              m_axis_rd_tvalid <= 1'b1;
`ifdef BPI_FLASH_ARB_TIMEOUT_EN
              m_axis_rd_tuser  <= 1'b0;
`endif
              state            <= ST_RETURN;
            end
          end
`ifdef BPI_FLASH_ARB_TIMEOUT_EN
          else if (wait_cnt == C_CNT_W'(C_TIMEOUT_CYCLES - 1)) begin
            if (m_axis_op_tuser) begin
              wr_timeout <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              m_axis_rd_tdata  <= '0;
              m_axis_rd_tuser  <= 1'b1;
              m_axis_rd_tvalid <= 1'b1;
              state            <= ST_RETURN;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_RETURN: begin
          if (m_axis_rd_tready) begin
            m_axis_rd_tvalid <= 1'b0;
            busy             <= 1'b0;
            state            <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpi_flash_access_arbiter.sv
// Scoreboard bench for bpi_flash_access_arbiter; timeout scenarios run when BPI_FLASH_ARB_TIMEOUT_EN is defined.
module tb_bpi_flash_access_arbiter;

  localparam int DW = 16;
  localparam int AW = 26;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] dest;
    logic          tuser;
  } op_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tuser;
  } rd_t;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          busy;
  logic [DW-1:0] wr_tdata;
  logic [AW-1:0] wr_tdest;
  logic          wr_tvalid;
  logic          wr_tready;
  logic [AW-1:0] rd_addr;
  logic          rd_tvalid_in;
  logic          rd_tready_out;
  logic [DW-1:0] rd_tdata;
  logic          rd_tuser;
  logic          rd_tvalid;
  logic          rd_tready;
  logic [DW-1:0] op_tdata;
  logic [AW-1:0] op_tdest;
  logic          op_tuser;
  logic          op_tvalid;
  logic          op_tready;
  logic [DW-1:0] done_tdata;
  logic          done_tvalid;
  logic          wr_timeout;

  op_t op_q[$];
  rd_t rd_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  dual_ready = 1'b0;

  bpi_flash_access_arbiter #(
    .C_MEM_WIDTH      (16),
    .C_MEM_SIZE       (134217728),
    .C_TIMEOUT_CYCLES (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .busy              (busy),
    .s_axis_wr_tdata   (wr_tdata),
    .s_axis_wr_tdest   (wr_tdest),
    .s_axis_wr_tvalid  (wr_tvalid),
    .s_axis_wr_tready  (wr_tready),
    .s_axis_rd_tdata   (rd_addr),
    .s_axis_rd_tvalid  (rd_tvalid_in),
    .s_axis_rd_tready  (rd_tready_out),
    .m_axis_rd_tdata   (rd_tdata),
    .m_axis_rd_tuser   (rd_tuser),
    .m_axis_rd_tvalid  (rd_tvalid),
    .m_axis_rd_tready  (rd_tready),
    .m_axis_op_tdata   (op_tdata),
    .m_axis_op_tdest   (op_tdest),
    .m_axis_op_tuser   (op_tuser),
    .m_axis_op_tvalid  (op_tvalid),
    .m_axis_op_tready  (op_tready),
    .s_phy_done_tdata  (done_tdata),
    .s_phy_done_tvalid (done_tvalid),
    .wr_timeout        (wr_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (wr_tready && rd_tready_out) dual_ready = 1'b1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global time limit");
  end

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b1;
    wr_tdata = '0; wr_tdest = '0; wr_tvalid = 1'b0;
    rd_addr = '0; rd_tvalid_in = 1'b0; rd_tready = 1'b1;
    op_tready = 1'b1; done_tdata = '0; done_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    op_q.delete(); rd_q.delete();
  endtask

  task automatic wait_op_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (op_tvalid) begin seen = 1'b1; break; end
    end
  endtask

  task automatic wait_rd_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_tvalid) begin seen = 1'b1; break; end
    end
  endtask

  task automatic pulse_done(input logic [DW-1:0] d);
    @(posedge clk); #1;
    done_tvalid = 1'b1; done_tdata = d;
    @(posedge clk); #1;
    done_tvalid = 1'b0; done_tdata = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({busy, op_tvalid, rd_tvalid, op_tuser, rd_tuser, wr_timeout, wr_tready, rd_tready_out} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000000",
        {busy, op_tvalid, rd_tvalid, op_tuser, rd_tuser, wr_timeout, wr_tready, rd_tready_out});
    end
    n_checks++;
    if ({op_tdata, op_tdest, rd_tdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {op_tdata, op_tdest, rd_tdata});
    end
  endtask

  task automatic test_single_write();
    op_t exp, got; bit seen;
    @(posedge clk); #1;
    op_tready = 1'b1;
    wr_tdata = 16'hBEEF; wr_tdest = 26'h1234; wr_tvalid = 1'b1;
    op_q.push_back({16'hBEEF, 26'h1234, 1'b1});
    @(negedge clk);
    n_checks++;
    if (wr_tready !== 1'b1) begin n_fail++; $display("FAIL wr_tready_idle: got %b expected 1", wr_tready); end
    @(posedge clk); #1 wr_tvalid = 1'b0;
    wait_op_valid(seen);
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL wr_op_wait: op_tvalid never seen, expected 1"); end
    got = {op_tdata, op_tdest, op_tuser};
    exp = op_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL wr_op_fields: got %h expected %h", got, exp); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1 done_tvalid = 1'b1;
    @(posedge clk); #1 done_tvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, op_tvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_complete: got busy/op_tvalid %b expected 00", {busy, op_tvalid}); end
  endtask

  task automatic test_single_read();
    op_t exp, got; rd_t rexp, rgot; bit seen;
    @(posedge clk); #1;
    op_tready = 1'b1; rd_tready = 1'b1;
    rd_addr = 26'h0010; rd_tvalid_in = 1'b1;
    op_q.push_back({16'h0000, 26'h0010, 1'b0});
    @(negedge clk);
    n_checks++;
    if ({wr_tready, rd_tready_out} !== 2'b01) begin n_fail++; $display("FAIL rd_tready_idle: got %b expected 01", {wr_tready, rd_tready_out}); end
    @(posedge clk); #1 rd_tvalid_in = 1'b0;
    wait_op_valid(seen);
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL rd_op_wait: op_tvalid never seen, expected 1"); end
    got = {op_tdata, op_tdest, op_tuser};
    exp = op_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rd_op_fields: got %h expected %h", got, exp); end
    rd_q.push_back({16'hA5A5, 1'b0});
    pulse_done(16'hA5A5);
    wait_rd_valid(seen);
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL rd_ret_wait: rd_tvalid never seen, expected 1"); end
    rgot = {rd_tdata, rd_tuser};
    rexp = rd_q.pop_front();
    n_checks++;
    if (rgot !== rexp) begin n_fail++; $display("FAIL rd_ret_data: got %h expected %h", rgot, rexp); end
    @(negedge clk);
    n_checks++;
    if ({busy, rd_tvalid} !== 2'b00) begin n_fail++; $display("FAIL rd_complete: got %b expected 00", {busy, rd_tvalid}); end
  endtask

  task automatic test_back_to_back();
    op_t exp, got; rd_t rexp, rgot; bit seen;
    apply_reset();
    dual_ready = 1'b0;
    wr_tdata = 16'hC0DE; wr_tdest = 26'h200; rd_addr = 26'h300;
    for (int k = 0; k < 4; k++)
      op_q.push_back((k % 2 == 0) ? op_t'({16'hC0DE, 26'h200, 1'b1}) : op_t'({16'h0000, 26'h300, 1'b0}));
    @(posedge clk); #1;
    wr_tvalid = 1'b1; rd_tvalid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_op_valid(seen);
      n_checks++;
      if (seen !== 1'b1) begin n_fail++; $display("FAIL b2b_op_wait[%0d]: op_tvalid never seen", k); end
      got = {op_tdata, op_tdest, op_tuser};
      exp = op_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %h expected %h", k, got, exp); end
      if (k == 3) begin wr_tvalid = 1'b0; rd_tvalid_in = 1'b0; end
      if (exp.tuser) begin
        pulse_done(16'h0000);
      end else begin
        rd_q.push_back({16'h1000 + 16'(k), 1'b0});
        pulse_done(16'h1000 + 16'(k));
        wait_rd_valid(seen);
        rgot = {rd_tdata, rd_tuser};
        rexp = rd_q.pop_front();
        n_checks++;
        if (seen !== 1'b1 || rgot !== rexp) begin n_fail++; $display("FAIL b2b_rd[%0d]: got %h expected %h", k, rgot, rexp); end
      end
    end
    @(negedge clk);
    n_checks++;
    if (dual_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_dual_tready: got %b expected 0", dual_ready); end
  endtask

  task automatic test_stall();
    op_t exp; rd_t rexp; bit seen;
    @(posedge clk); #1;
    op_tready = 1'b0;
    wr_tdata = 16'h5A5A; wr_tdest = 26'h777; wr_tvalid = 1'b1;
    exp = {16'h5A5A, 26'h777, 1'b1};
    @(posedge clk); #1;
    wr_tvalid = 1'b0; rd_addr = 26'h42; rd_tvalid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({op_tvalid, op_tdata, op_tdest, op_tuser} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL op_stall[%0d]: got %h expected %h", i, {op_tvalid, op_tdata, op_tdest, op_tuser}, {1'b1, exp});
      end
      n_checks++;
      if (rd_tready_out !== 1'b0) begin n_fail++; $display("FAIL op_stall_accept[%0d]: rd_tready got %b expected 0", i, rd_tready_out); end
    end
    rd_tvalid_in = 1'b0; op_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (op_tvalid !== 1'b0) begin n_fail++; $display("FAIL op_stall_release: op_tvalid got %b expected 0", op_tvalid); end
    pulse_done(16'h0000);
    rd_tready = 1'b0; rd_addr = 26'h42; rd_tvalid_in = 1'b1;
    @(posedge clk); #1;
    rd_tvalid_in = 1'b0; wr_tdata = 16'h1111; wr_tdest = 26'h11; wr_tvalid = 1'b1;
    wait_op_valid(seen);
    rd_q.push_back({16'h3C3C, 1'b0});
    pulse_done(16'h3C3C);
    rexp = rd_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_tvalid, rd_tdata, rd_tuser} !== {1'b1, rexp}) begin
        n_fail++; $display("FAIL rd_stall[%0d]: got %h expected %h", i, {rd_tvalid, rd_tdata, rd_tuser}, {1'b1, rexp});
      end
      n_checks++;
      if (wr_tready !== 1'b0) begin n_fail++; $display("FAIL rd_stall_accept[%0d]: wr_tready got %b expected 0", i, wr_tready); end
    end
    wr_tvalid = 1'b0; rd_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, rd_tvalid} !== 2'b00) begin n_fail++; $display("FAIL rd_stall_release: got %b expected 00", {busy, rd_tvalid}); end
  endtask

  task automatic test_enable();
    op_t exp, got; bit seen;
    @(posedge clk); #1;
    enable = 1'b0;
    wr_tdata = 16'h1357; wr_tdest = 26'h99; wr_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, wr_tready} !== 2'b00) begin n_fail++; $display("FAIL en_low_hold[%0d]: got %b expected 00", i, {busy, wr_tready}); end
    end
    op_q.push_back({16'h1357, 26'h99, 1'b1});
    enable = 1'b1;
    @(posedge clk); #1 wr_tvalid = 1'b0;
    wait_op_valid(seen);
    got = {op_tdata, op_tdest, op_tuser};
    exp = op_q.pop_front();
    n_checks++;
    if (seen !== 1'b1 || got !== exp) begin n_fail++; $display("FAIL en_op: got %h expected %h", got, exp); end
    enable = 1'b0;
    pulse_done(16'h0000);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL en_mid_op_complete: busy got %b expected 0", busy); end
    enable = 1'b1;
  endtask

`ifdef BPI_FLASH_ARB_TIMEOUT_EN
  task automatic test_timeout();
    rd_t rexp, rgot; bit seen, seen_to; int cyc;
    @(posedge clk); #1;
    op_tready = 1'b1; rd_tready = 1'b1;
    wr_tdata = 16'hDEAD; wr_tdest = 26'h10; wr_tvalid = 1'b1;
    @(posedge clk); #1 wr_tvalid = 1'b0;
    wait_op_valid(seen);
    cyc = 0; seen_to = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (wr_timeout) begin seen_to = 1'b1; break; end
    end
    n_checks++;
    if (seen_to !== 1'b1 || cyc != 17) begin n_fail++; $display("FAIL wr_timeout_pulse: seen %b after %0d cycles, expected 1 after 17", seen_to, cyc); end
    @(negedge clk);
    n_checks++;
    if ({wr_timeout, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_timeout_width: got %b expected 00", {wr_timeout, busy}); end
    @(posedge clk); #1;
    rd_addr = 26'h20; rd_tvalid_in = 1'b1;
    @(posedge clk); #1 rd_tvalid_in = 1'b0;
    rd_q.push_back({16'h0000, 1'b1});
    wait_op_valid(seen);
    wait_rd_valid(seen);
    rgot = {rd_tdata, rd_tuser};
    rexp = rd_q.pop_front();
    n_checks++;
    if (seen !== 1'b1 || rgot !== rexp) begin n_fail++; $display("FAIL rd_timeout: got %h expected %h", rgot, rexp); end
    @(negedge clk);
  endtask
`else
  task automatic test_timeout();
    bit seen, bad;
    @(posedge clk); #1;
    op_tready = 1'b1;
    wr_tdata = 16'hDEAD; wr_tdest = 26'h10; wr_tvalid = 1'b1;
    @(posedge clk); #1 wr_tvalid = 1'b0;
    wait_op_valid(seen);
    @(posedge clk);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wr_timeout || !busy) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL no_timeout_wait: early exit %b expected 0", bad); end
    pulse_done(16'h0000);
    @(negedge clk);
    n_checks++;
    if ({busy, wr_timeout} !== 2'b00) begin n_fail++; $display("FAIL no_timeout_done: got %b expected 00", {busy, wr_timeout}); end
  endtask
`endif

  task automatic test_reset_mid_op();
    bit seen;
    @(posedge clk); #1;
    op_tready = 1'b1; rd_tready = 1'b1;
    rd_addr = 26'h55; rd_tvalid_in = 1'b1;
    @(posedge clk); #1 rd_tvalid_in = 1'b0;
    wait_op_valid(seen);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({busy, op_tvalid} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_wait: got %b expected 10", {busy, op_tvalid}); end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    op_q.delete(); rd_q.delete();
    done_tvalid = 1'b1; done_tdata = 16'hFFFF;
    @(posedge clk); #1 done_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, rd_tvalid, op_tvalid, rd_tuser, wr_timeout} !== 5'b00000) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b expected 00000", {busy, rd_tvalid, op_tvalid, rd_tuser, wr_timeout});
    end
    n_checks++;
    if ({rd_tdata, op_tdata, op_tdest, op_tuser} !== '0) begin
      n_fail++; $display("FAIL rst_mid_data: got %h expected 0", {rd_tdata, op_tdata, op_tdest, op_tuser});
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_stall();
    test_enable();
    test_timeout();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
